keystroke_debounce: RTL and testbench



---
 rtl/keystroke_debounce.sv | 137 +++++++++++++
 tb/tb_keystroke_debounce.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/keystroke_debounce.sv
// keystroke_debounce: synchronises, debounces and edge-detects raw key inputs.
// Each bit is handled by its own keystroke_debounce_bit lane.
// Optional macro KEY_REPEAT_EN adds auto-repeat press pulses on held keys
// selected by REPEAT_MASK.

module keystroke_debounce_bit #(
  parameter int DB_CYCLES    = 16
`ifdef KEY_REPEAT_EN
  , parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000,
  parameter bit REPEAT_ON    = 1'b0
`endif
) (
  input  logic clk_raw,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DB_CYCLES);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  // armed_q: first repeat (REPEAT_DELAY) already emitted, later ones use REPEAT_RATE
  logic [RW-1:0] rep_q, rep_d;
  logic          armed_q, armed_d;
`endif

  // Next-state: synchroniser shift, stability counter, level accept, press pulse
  always_comb begin
    s1_d    = key_raw_i;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      level_d = s2_q;
      cnt_d   = '0;
      press_d = s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`ifdef KEY_REPEAT_EN
    rep_d   = rep_q;
    armed_d = armed_q;
    // Count only while the key stays accepted-high; a fall being accepted
    // this cycle clears the counter and suppresses any coincident repeat.
    if (REPEAT_ON && level_q && level_d) begin
      if (rep_q == (armed_q ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
        press_d = 1'b1;
        rep_d   = '0;
        armed_d = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end else begin
      rep_d   = '0;
      armed_d = 1'b0;
    end
`endif
  end

  // Debounce state registers, cleared asynchronously
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat counter registers
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      rep_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      rep_q   <= rep_d;
      armed_q <= armed_d;
    end
  end
`endif

  assign level_o = level_q;
  assign press_o = press_q;
endmodule

module keystroke_debounce #(
  parameter int               WIDTH        = 12,
  parameter int               DB_CYCLES    = 16,
  parameter int               REPEAT_DELAY = 500000,
  parameter int               REPEAT_RATE  = 100000,
  parameter logic [WIDTH-1:0] REPEAT_MASK  = WIDTH'(12'h100)
) (
  input  logic             clk_raw,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] keystroke,
  output logic [WIDTH-1:0] key_press
);
  // One independent debounce lane per key bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    keystroke_debounce_bit #(
      .DB_CYCLES   (DB_CYCLES)
`ifdef KEY_REPEAT_EN
      , .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_ON   (REPEAT_MASK[i])
`endif
    ) u_bit (
      .clk_raw  (clk_raw),
      .rst_n    (rst_n),
      .key_raw_i(key_raw[i]),
      .level_o  (keystroke[i]),
      .press_o  (key_press[i])
    );
  end
endmodule

// File: tb/tb_keystroke_debounce.sv
// tb_keystroke_debounce: directed stimulus pushes expected output events
// (cycle, keystroke, key_press) into a queue; a negedge monitor pops one
// entry whenever keystroke changes or key_press is non-zero.

module tb_keystroke_debounce;
  localparam int W = 12;

  logic         clk_raw;
  logic         rst_n;
  logic [W-1:0] key_raw;
  logic [W-1:0] keystroke;
  logic [W-1:0] key_press;

  typedef struct {
    int           cyc;
    logic [W-1:0] ks;
    logic [W-1:0] kp;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] prev_ks = '0;

  keystroke_debounce #(
    .WIDTH(W), .DB_CYCLES(16), .REPEAT_DELAY(40), .REPEAT_RATE(10),
    .REPEAT_MASK(12'h100)
  ) dut (
    .clk_raw(clk_raw), .rst_n(rst_n), .key_raw(key_raw),
    .keystroke(keystroke), .key_press(key_press)
  );

  initial clk_raw = 1'b0;
  always #5 clk_raw = ~clk_raw;

  always @(posedge clk_raw) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // expected event dcyc edges after the current cycle
  task automatic push(input int dcyc, input logic [W-1:0] ks, input logic [W-1:0] kp);
    exp_t e;
    e.cyc = cyc + dcyc;
    e.ks  = ks;
    e.kp  = kp;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_raw);
    #1;
  endtask

  // Monitor: compare every observable output event against the scoreboard
  always @(negedge clk_raw) begin
    if (!rst_n) begin
      prev_ks = keystroke;
    end else begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_event actual_cyc=%0d expected_cyc=%0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (key_press != '0 || keystroke != prev_ks) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event cyc=%0d keystroke=%0h key_press=%0h expected=none",
                   cyc, keystroke, key_press);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_keystroke", int'(keystroke), int'(e.ks));
          chk("event_key_press", int'(key_press), int'(e.kp));
        end
      end
      prev_ks = keystroke;
    end
  end

  initial begin
    rst_n   = 1'b0;
    key_raw = '0;
    step(3);
    chk("reset_keystroke", int'(keystroke), 0);
    chk("reset_key_press", int'(key_press), 0);

    // keys held through reset are a fresh press 18 edges after release
    key_raw = 12'h082;
    rst_n   = 1'b1;
    push(18, 12'h082, 12'h082);
    step(30);

    // bit 9 bounces 1,0,1,0 for 5 cycles each, then settles high
    key_raw[9] = 1'b1; step(5);
    key_raw[9] = 1'b0; step(5);
    key_raw[9] = 1'b1; step(5);
    key_raw[9] = 1'b0; step(5);
    key_raw[9] = 1'b1;
    push(18, 12'h282, 12'h200);
    step(30);

    // 2-cycle glitch on bit 8 is rejected
    key_raw[8] = 1'b1; step(2);
    key_raw[8] = 1'b0; step(30);
    chk("glitch_keystroke", int'(keystroke), 12'h282);
    chk("glitch_key_press", int'(key_press), 0);

    // hold bit 8 for 100 cycles; release produces a level change without pulse
    key_raw[8] = 1'b1;
    push(18, 12'h382, 12'h100);
`ifdef KEY_REPEAT_EN
    // repeats at acceptance+40, then every 10 while the level is still high
    for (int j = 0; j < 6; j++) push(18 + 40 + 10 * j, 12'h382, 12'h100);
`endif
    step(100);
    key_raw[8] = 1'b0;
    push(18, 12'h282, 12'h000);
    step(30);

    // reset mid-debounce (all changing counters at 10) clears outputs at once
    key_raw = '0;
    step(12);
    rst_n = 1'b0;
    #1;
    chk("midreset_keystroke", int'(keystroke), 0);
    chk("midreset_key_press", int'(key_press), 0);
    step(3);
    rst_n = 1'b1;
    step(30);
    chk("postreset_keystroke", int'(keystroke), 0);
    chk("postreset_key_press", int'(key_press), 0);

    // bits 1 and 7 change together and update on the same edge
    key_raw = 12'h082;
    push(18, 12'h082, 12'h082);
    step(30);
    key_raw = '0;
    push(18, 12'h000, 12'h000);
    step(30);

    step(5);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
